// File: rtl/carry_lookahead_adder.sv
// rtl/carry_lookahead_adder.sv - two-level carry lookahead adder with registered outputs
// Optional signed overflow flag enabled by defining CLA_OVERFLOW_EN.
module carry_lookahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q
);

  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0]    w_g;
  logic [PW-1:0]    w_p;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_c;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  // Pad bits propagate without generating, so the top group carry equals c[WIDTH].
  always_comb begin
    w_g = '0;
    w_p = '1;
    w_g[WIDTH-1:0] = a & b;
    w_p[WIDTH-1:0] = a ^ b;

    w_gg = '0;
    w_gp = '0;
    for (int gi = 0; gi < NG; gi++) begin
      w_gp[gi] = &w_p[gi*4 +: 4];
      for (int k = 0; k < 4; k++) begin
        logic t;
        t = w_g[gi*4 + k];
        for (int m = k + 1; m < 4; m++) t = t & w_p[gi*4 + m];
        w_gg[gi] = w_gg[gi] | t;
      end
    end

    w_gc    = '0;
    w_gc[0] = cin;
    for (int gi = 1; gi <= NG; gi++) begin
      logic acc;
      acc = 1'b0;
      for (int k = 0; k <= gi; k++) begin
        logic t;
        t = (k == 0) ? cin : w_gg[k-1];
        for (int m = k; m < gi; m++) t = t & w_gp[m];
        acc = acc | t;
      end
      w_gc[gi] = acc;
    end

    // Each in-group carry is a flat sum of products off the group carry-in.
    w_c = '0;
    for (int gi = 0; gi < NG; gi++) begin
      for (int j = 0; j < 4; j++) begin
        logic acc;
        acc = 1'b0;
        for (int k = 0; k <= j; k++) begin
          logic t;
          t = (k == 0) ? w_gc[gi] : w_g[gi*4 + k - 1];
          for (int m = k; m < j; m++) t = t & w_p[gi*4 + m];
          acc = acc | t;
        end
        if (gi*4 + j < WIDTH) w_c[gi*4 + j] = acc;
      end
    end
  end

`ifdef CLA_OVERFLOW_EN
  assign w_ovf = w_c[WIDTH-1] ^ w_gc[NG];
`else
  assign w_ovf = 1'b0;
`endif

  assign sum       = w_p[WIDTH-1:0] ^ w_c;
  assign carry_out = w_gc[NG];
  assign overflow  = w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sum   <= sum;
      r_carry <= carry_out;
      r_ovf   <= w_ovf;
    end
  end

  assign sum_q       = r_sum;
  assign carry_out_q = r_carry;
  assign overflow_q  = r_ovf;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// tb/tb_carry_lookahead_adder.sv - randomized and directed checks against an arithmetic model
// Covers WIDTH=4 (exhaustive, registered path, reset) and WIDTH=10 (partial top group).
module tb_carry_lookahead_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic [3:0] sum4, sum4_q;
  logic       co4, co4_q, ov4, ov4_q;

  logic [9:0] a10 = '0, b10 = '0;
  logic       cin10 = 1'b0;
  logic [9:0] sum10, sum10_q;
  logic       co10, co10_q, ov10, ov10_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  carry_lookahead_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .carry_out(co4), .overflow(ov4),
    .sum_q(sum4_q), .carry_out_q(co4_q), .overflow_q(ov4_q)
  );

  carry_lookahead_adder #(.WIDTH(10)) u_dut10 (
    .clk(clk), .rst(rst), .a(a10), .b(b10), .cin(cin10),
    .sum(sum10), .carry_out(co10), .overflow(ov10),
    .sum_q(sum10_q), .carry_out_q(co10_q), .overflow_q(ov10_q)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_sum(input longint av, input longint bv, input longint cv);
    return 64'(av + bv + cv);
  endfunction

  function automatic logic ref_ovf(input int w, input longint av, input longint bv, input longint cv);
`ifdef CLA_OVERFLOW_EN
    longint full, sa, sb, s;
    full = longint'(1) << w;
    sa = (av >= full / 2) ? av - full : av;
    sb = (bv >= full / 2) ? bv - full : bv;
    s  = sa + sb + cv;
    return (s > full / 2 - 1) || (s < -(full / 2));
`else
    return (w < 0) && (av + bv + cv < 0);
`endif
  endfunction

  initial begin
    logic [63:0] e;

    #2;
    check("reset_sum_q", 64'(sum4_q), 64'd0);
    check("reset_co_q", 64'(co4_q), 64'd0);
    check("reset_ov_q", 64'(ov4_q), 64'd0);

    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
      #5;
      e = ref_sum(a4, b4, cin4);
      check("exh4_sum_co", 64'({co4, sum4}), e & 64'h1F);
      check("exh4_ovf", 64'(ov4), 64'(ref_ovf(4, a4, b4, cin4)));
    end

    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; #5;
    check("f_0_1_sum", 64'(sum4), 64'h0);
    check("f_0_1_co", 64'(co4), 64'd1);
    check("f_0_1_ovf", 64'(ov4), 64'd0);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; #5;
    check("f_f_1_sum", 64'(sum4), 64'hF);
    check("f_f_1_co", 64'(co4), 64'd1);
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0; #5;
    check("7_1_sum", 64'(sum4), 64'h8);
    check("7_1_co", 64'(co4), 64'd0);
`ifdef CLA_OVERFLOW_EN
    check("7_1_ovf", 64'(ov4), 64'd1);
`else
    check("7_1_ovf", 64'(ov4), 64'd0);
`endif

    a10 = 10'h3FF; b10 = 10'h001; cin10 = 1'b0; #5;
    check("w10_carry_sum", 64'(sum10), 64'h0);
    check("w10_carry_co", 64'(co10), 64'd1);
    a10 = 10'h3FF; b10 = 10'h000; cin10 = 1'b1; #5;
    check("w10_cin_sum", 64'(sum10), 64'h0);
    check("w10_cin_co", 64'(co10), 64'd1);
    a10 = 10'h3FF; b10 = 10'h3FF; cin10 = 1'b1; #5;
    check("w10_ones_sum", 64'({co10, sum10}), 64'h7FF);
    a10 = 10'h0; b10 = 10'h0; cin10 = 1'b0; #5;
    check("w10_zero", 64'({ov10, co10, sum10}), 64'h0);

    for (int i = 0; i < 10000; i++) begin
      a10 = 10'($urandom); b10 = 10'($urandom); cin10 = 1'($urandom);
      #5;
      e = ref_sum(a10, b10, cin10);
      check("rnd10_sum_co", 64'({co10, sum10}), e & 64'h7FF);
      check("rnd10_ovf", 64'(ov10), 64'(ref_ovf(10, a10, b10, cin10)));
    end

    // Registered path and asynchronous reset on the WIDTH=4 instance.
    @(negedge clk);
    check("rst_held_sum_q", 64'(sum10_q), 64'd0);
    rst = 1'b0;
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    @(posedge clk); #1;
    check("first_edge_load", 64'({co4_q, sum4_q}), 64'd0);
    a4 = 4'd3; b4 = 4'd4; cin4 = 1'b1;
    #1;
    check("comb_3_4_1", 64'(sum4), 64'd8);
    check("pre_edge_sum_q", 64'(sum4_q), 64'd0);
    @(posedge clk); #1;
    check("reg_sum_q", 64'(sum4_q), 64'd8);
    check("reg_co_q", 64'(co4_q), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum_q", 64'(sum4_q), 64'd0);
    check("async_rst_co_q", 64'(co4_q), 64'd0);
    check("rst_comb_sum", 64'(sum4), 64'd8);
    @(posedge clk); #1;
    check("rst_over_edge", 64'(sum4_q), 64'd0);
    #1 rst = 1'b0;
    #1;
    check("rst_fall_no_load", 64'(sum4_q), 64'd0);
    @(posedge clk); #1;
    check("reload_sum_q", 64'(sum4_q), 64'd8);
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    @(posedge clk); #1;
    check("reg_7_1", 64'({ov4_q, co4_q, sum4_q}), {62'd0, ref_ovf(4, 7, 1, 0), 1'b0} << 4 | 64'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/carry_lookahead_adder.md
CARRY_LOOKAHEAD_ADDER -- requirements
Module: carry_lookahead_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all registered outputs update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 a  input  WIDTH  unsigned operand A.
REQ-005 b  input  WIDTH  unsigned operand B.
REQ-006 cin  input  1  carry in.
REQ-007 sum  output  WIDTH  combinational sum bits.
REQ-008 carry_out  output  1  combinational carry out of the MSB.
REQ-009 overflow  output  1  combinational two's-complement overflow flag; see Configuration.
REQ-010 sum_q  output  WIDTH  registered copy of sum.
REQ-011 carry_out_q  output  1  registered copy of carry_out.
REQ-012 overflow_q  output  1  registered copy of overflow.

Function
REQ-013 {carry_out, sum} SHALL equal a + b + cin, computed at WIDTH+1 bits, for every input combination.
REQ-014 sum, carry_out and overflow SHALL be purely combinational, with zero clock latency, and SHALL settle within one evaluation with no dependence on clk or rst.
REQ-015 Per-bit generate g[i] = a[i]&b[i]; per-bit propagate p[i] = a[i]^b[i]; sum[i] = p[i]^c[i]; c[0] = cin.
REQ-016 Bits SHALL be partitioned into 4-bit groups from the LSB; the last group holds WIDTH mod 4 bits when WIDTH is not a multiple of 4.
REQ-017 Carries inside each group SHALL be expanded lookahead equations from g, p and the group carry-in; no ripple chain between bits.
REQ-018 Each group SHALL produce group generate GG and group propagate GP; group carry-ins SHALL come from a second-level lookahead unit over GG/GP and cin.
REQ-019 carry_out SHALL equal the carry out of the top group.
REQ-020 Boundary cases: all-ones + all-ones + 1 gives sum all-ones and carry_out 1; all-ones + 0 + 1 gives sum 0 and carry_out 1, with the carry propagating through every group; 0 + 0 + 0 gives all zeros.
REQ-021 On every rising clk edge with rst low, sum_q, carry_out_q and overflow_q SHALL load sum, carry_out and overflow, giving 1-cycle latency.
REQ-022 No X SHALL appear on any output when all inputs are known.

Reset
REQ-023 While rst is high, sum_q, carry_out_q and overflow_q SHALL be 0 immediately, without waiting for a clock edge.
REQ-024 rst SHALL NOT affect sum, carry_out or overflow.
REQ-025 After rst deasserts, registers SHALL load on the first rising clk edge.
REQ-026 Asserting rst mid-operation SHALL clear the registered outputs at once.
REQ-027 Registered outputs SHALL resume loading at the next edge after rst falls.

Configuration
REQ-028 Macro CLA_OVERFLOW_EN: when defined, overflow SHALL equal c[WIDTH-1] ^ carry_out, the signed overflow.
REQ-029 When CLA_OVERFLOW_EN is undefined, overflow and overflow_q SHALL be constant 0.
REQ-030 The port list SHALL be identical in both CLA_OVERFLOW_EN builds.

Verification
REQ-031 Exhaustive, WIDTH=4: all 512 combinations of a, b, cin, checked 5 time units after each change -> {carry_out, sum} == a+b+cin every time.
REQ-032 WIDTH=4: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, carry_out=1; with CLA_OVERFLOW_EN defined, overflow=0.
REQ-033 WIDTH=4 with CLA_OVERFLOW_EN defined: a=4'h7, b=4'h1, cin=0 -> sum=4'h8, carry_out=0, overflow=1; without the macro, overflow=0.
REQ-034 WIDTH=10: a=10'h3FF, b=10'h001, cin=0 -> sum=0, carry_out=1 (carry crosses the partial top group); random sweep of 10k vectors matches the reference sum.
REQ-035 Registered path: apply a=3, b=4, cin=1 -> sum_q=8, carry_out_q=0 after exactly one rising edge, not before.
REQ-036 Async reset: raise rst between edges -> registered outputs 0 immediately while sum stays 8; after rst falls, the next edge reloads the registered outputs.
